ip_tx_arbiter: RTL and testbench
================================

// Module: ip_tx_arbiter
// PURPOSE
// Shares the single ip_tx framer between the UDP and ICMP transmit engines.
// Arbitrates round-robin and latches the winner's protocol type, length and destination IP for the whole frame.
// Routes the handshakes: ip_tx_req/ack, upper_tx_ready, upper_data_req, ip_tx_end.
// Sits between udp_tx/icmp_tx and ip_tx. ip_tx feeds mac_tx.
// PARAMETERS
// TIMEOUT_CYCLES  20'd200000  cycles allowed in WAIT_ACK or XFER before the frame is abandoned
// GAP_CYCLES      8'd12       idle cycles enforced after each frame before the next grant
// PORTS
// clk                  in   1   system clock
// rst_n                in   1   asynchronous active-low reset
// udp_tx_req           in   1   UDP frame pending (level, held until udp_tx_ack)
// udp_tx_ready         in   1   UDP payload available
// udp_send_length      in   16  UDP IP-payload length in bytes
// udp_dst_ip           in   32  UDP destination IP
// udp_tx_data          in   8   UDP payload byte
// udp_tx_ack           out  1   1-cycle grant acknowledge to UDP
// udp_data_req         out  1   payload request forwarded to UDP
// udp_tx_end           out  1   1-cycle frame-complete to UDP
// icmp_*               --   --  identical set of 8 ports for the ICMP requester
// ip_tx_req            out  1   frame request to ip_tx
// ip_send_type         out  8   latched protocol: 8'h11 for UDP, 8'h01 for ICMP
// ip_send_data_length  out  16  latched length
// destination_ip_addr  out  32  latched destination IP
// upper_layer_data     out  8   payload byte muxed from the granted requester
// upper_tx_ready       out  1   ready muxed from the granted requester
// ip_tx_ack            in   1   from ip_tx; a multi-cycle level
// upper_data_req       in   1   from ip_tx
// ip_tx_end            in   1   from ip_tx; 1-cycle pulse
// tx_abort             out  1   1-cycle pulse when a frame is abandoned on timeout
// BEHAVIOUR
// - All outputs reset to 0. grant resets to NONE. last_grant resets to UDP, so ICMP wins the first tie.
// - States:
//   IDLE -> WAIT_ACK when either request is high. The winner is registered in the same cycle.
//   WAIT_ACK -> XFER on the rising edge of ip_tx_ack.
//   XFER -> GAP on ip_tx_end.
//   GAP -> IDLE after GAP_CYCLES.
//   WAIT_ACK or XFER -> IDLE with tx_abort when timeout reaches TIMEOUT_CYCLES-1.
// - Arbitration:
//   One request high: that requester wins.
//   Both high: the requester that is not last_grant wins.
//   last_grant updates at grant time.
// - On the IDLE->WAIT_ACK transition, latch ip_send_type, ip_send_data_length and destination_ip_addr from the winner.
//   These hold until the next grant. Latency from request to ip_tx_req is 1 cycle.
// - ip_tx_req is high for the whole of WAIT_ACK and drops the cycle after the first ip_tx_ack.
// - <req>_tx_ack: a single pulse to the granted requester on the ip_tx_ack rising edge.
//   The remaining ack-high cycles are not forwarded.
// - upper_tx_ready and upper_layer_data are combinational muxes on grant.
//   Both are 0 when grant is NONE.
// - upper_data_req -> <granted>_data_req, combinational. Never routed to the non-granted requester.
// - ip_tx_end -> <granted>_tx_end, registered: 1 cycle late.
//   ip_tx_end outside XFER is ignored.
// - grant is cleared on entry to GAP or IDLE.
// - Requests are ignored from WAIT_ACK through GAP. A requester dropping its req after grant does not cancel the frame.
// - timeout: a 20-bit counter, cleared on every state change, incrementing in WAIT_ACK and XFER.
// - Reset mid-frame: everything returns to reset values and ip_tx_req drops asynchronously.
// STRUCTURE
// - Shared package ip_pkg:
//   protocol constants PROTO_UDP=8'h11 and PROTO_ICMP=8'h01
//   grant encoding NONE/UDP/ICMP (2 bits)
//   one-hot state encoding IDLE/WAIT_ACK/XFER/GAP
// - Sub-module ip_tx_rr_arb: a 2-input round-robin arbiter.
//   Inputs: req[1:0], last_grant, enable.
//   Output: grant, the 1-hot winner.
//   Purely combinational apart from the last_grant register.
// TESTING
// - UDP only: req, length 16'd100, dst 32'hC0A8_0002 -> ip_tx_req 1 cycle later, ip_send_type 8'h11.
//   Stimulate ip_tx_ack high for 8 cycles -> exactly 1 udp_tx_ack pulse.
//   Then ip_tx_end -> udp_tx_end 1 cycle later, followed by 12 gap cycles.
// - Both request in the same cycle after reset -> ICMP granted, ip_send_type 8'h01.
//   After its end and the gap -> UDP granted, with no second ICMP grant in between.
// - upper_data_req pulse during a UDP frame -> udp_data_req high, icmp_data_req low.
//   upper_layer_data tracks udp_tx_data byte-for-byte.
// - udp_send_length changes 16'd100 -> 16'd40 mid-frame -> ip_send_data_length stays 16'd100 until the next grant.
// - No ip_tx_ack with TIMEOUT_CYCLES=64 -> tx_abort at cycle 64 of WAIT_ACK, ip_tx_req low, state IDLE, next request re-granted.
// - rst_n low during XFER -> all outputs 0 immediately. After release, a pending ICMP req is granted normally.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared constants and encodings for the IP transmit path arbiter.
package ip_pkg;

  // IP protocol numbers placed in the header by ip_tx
  localparam logic [7:0] PROTO_UDP  = 8'h11;
  localparam logic [7:0] PROTO_ICMP = 8'h01;

  // Grant encoding: doubles as a one-hot winner vector {icmp, udp}
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_UDP  = 2'b01,
    GNT_ICMP = 2'b10
  } grant_t;

  // One-hot arbiter FSM state
  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_WAIT_ACK = 4'b0010,
    ST_XFER     = 4'b0100,
    ST_GAP      = 4'b1000
  } state_t;

  // Protocol number that belongs to a given winner
  function automatic logic [7:0] proto_of(grant_t g);
    return (g == GNT_ICMP) ? PROTO_ICMP : PROTO_UDP;
  endfunction

endpackage

// File: rtl/ip_tx_rr_arb.sv
// Two-input round-robin pick. On a tie the requester that did not win
// last time is chosen; the last-winner register lives in the parent.
module ip_tx_rr_arb
  import ip_pkg::*;
(
  input  logic [1:0] req_i,        // {icmp, udp}
  input  grant_t     last_grant_i,
  input  logic       enable_i,
  output grant_t     grant_o
);

  // Combinational winner selection
  always_comb begin
    grant_o = GNT_NONE;
    if (enable_i) begin
      unique case (req_i)
        2'b01:   grant_o = GNT_UDP;
        2'b10:   grant_o = GNT_ICMP;
        2'b11:   grant_o = (last_grant_i == GNT_UDP) ? GNT_ICMP : GNT_UDP;
        default: grant_o = GNT_NONE;
      endcase
    end
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Shares the ip_tx framer between the UDP and ICMP transmit engines.
// Handshake: a requester holds <req>_tx_req high until it sees a one-cycle
// <req>_tx_ack; ip_tx_req is held high until the first cycle of ip_tx_ack,
// only its rising edge is forwarded, and ip_tx_end (one cycle) closes the
// frame and is returned to the owner one cycle later as <req>_tx_end.
module ip_tx_arbiter
  import ip_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  // UDP requester
  input  logic        udp_tx_req,
  input  logic        udp_tx_ready,
  input  logic [15:0] udp_send_length,
  input  logic [31:0] udp_dst_ip,
  input  logic [7:0]  udp_tx_data,
  output logic        udp_tx_ack,
  output logic        udp_data_req,
  output logic        udp_tx_end,
  // ICMP requester
  input  logic        icmp_tx_req,
  input  logic        icmp_tx_ready,
  input  logic [15:0] icmp_send_length,
  input  logic [31:0] icmp_dst_ip,
  input  logic [7:0]  icmp_tx_data,
  output logic        icmp_tx_ack,
  output logic        icmp_data_req,
  output logic        icmp_tx_end,
  // ip_tx side
  output logic        ip_tx_req,
  output logic [7:0]  ip_send_type,
  output logic [15:0] ip_send_data_length,
  output logic [31:0] destination_ip_addr,
  output logic [7:0]  upper_layer_data,
  output logic        upper_tx_ready,
  input  logic        ip_tx_ack,
  input  logic        upper_data_req,
  input  logic        ip_tx_end,
  output logic        tx_abort,
  // observation
  output state_t      dbg_state_o,
  output grant_t      dbg_grant_o
);

  localparam logic [19:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 20'd1;

  state_t      state_q;
  grant_t      grant_q;
  grant_t      last_grant_q;
  logic        ack_prev_q;
  logic [19:0] timeout_q;
  logic [7:0]  gap_cnt_q;
  logic        ip_tx_req_q;
  logic [7:0]  ip_type_q;
  logic [15:0] ip_len_q;
  logic [31:0] ip_dst_q;
  logic        udp_ack_q;
  logic        icmp_ack_q;
  logic        udp_end_q;
  logic        icmp_end_q;
  logic        abort_q;

  grant_t      win_d;
  logic        ack_rise_d;
  logic        gap_done_d;
  logic        timeout_hit_d;

  assign ack_rise_d    = ip_tx_ack & ~ack_prev_q;
  assign gap_done_d    = (gap_cnt_q + 8'd1) >= GAP_CYCLES;
  assign timeout_hit_d = (timeout_q == TIMEOUT_LAST);

  ip_tx_rr_arb u_rr_arb (
    .req_i        ({icmp_tx_req, udp_tx_req}),
    .last_grant_i (last_grant_q),
    .enable_i     (state_q == ST_IDLE),
    .grant_o      (win_d)
  );

  // Frame FSM: grant, latching of header fields and all registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_UDP;
      ack_prev_q   <= 1'b0;
      timeout_q    <= 20'd0;
      gap_cnt_q    <= 8'd0;
      ip_tx_req_q  <= 1'b0;
      ip_type_q    <= 8'd0;
      ip_len_q     <= 16'd0;
      ip_dst_q     <= 32'd0;
      udp_ack_q    <= 1'b0;
      icmp_ack_q   <= 1'b0;
      udp_end_q    <= 1'b0;
      icmp_end_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      ack_prev_q <= ip_tx_ack;
      udp_ack_q  <= 1'b0;
      icmp_ack_q <= 1'b0;
      udp_end_q  <= 1'b0;
      icmp_end_q <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timeout_q <= 20'd0;
          gap_cnt_q <= 8'd0;
          if (win_d != GNT_NONE) begin
            state_q      <= ST_WAIT_ACK;
            grant_q      <= win_d;
            last_grant_q <= win_d;
            ip_tx_req_q  <= 1'b1;
            ip_type_q    <= proto_of(win_d);
            ip_len_q     <= (win_d == GNT_ICMP) ? icmp_send_length : udp_send_length;
            ip_dst_q     <= (win_d == GNT_ICMP) ? icmp_dst_ip : udp_dst_ip;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_rise_d) begin
            state_q     <= ST_XFER;
            timeout_q   <= 20'd0;
            ip_tx_req_q <= 1'b0;
            udp_ack_q   <= (grant_q == GNT_UDP);
            icmp_ack_q  <= (grant_q == GNT_ICMP);
          end else if (timeout_hit_d) begin
            state_q     <= ST_IDLE;
            timeout_q   <= 20'd0;
            ip_tx_req_q <= 1'b0;
            grant_q     <= GNT_NONE;
            abort_q     <= 1'b1;
          end else begin
            timeout_q <= timeout_q + 20'd1;
          end
        end
        ST_XFER: begin
          if (ip_tx_end) begin
            state_q    <= ST_GAP;
            timeout_q  <= 20'd0;
            gap_cnt_q  <= 8'd0;
            grant_q    <= GNT_NONE;
            udp_end_q  <= (grant_q == GNT_UDP);
            icmp_end_q <= (grant_q == GNT_ICMP);
          end else if (timeout_hit_d) begin
            state_q   <= ST_IDLE;
            timeout_q <= 20'd0;
            grant_q   <= GNT_NONE;
            abort_q   <= 1'b1;
          end else begin
            timeout_q <= timeout_q + 20'd1;
          end
        end
        ST_GAP: begin
          if (gap_done_d) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= 8'd0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          grant_q     <= GNT_NONE;
          ip_tx_req_q <= 1'b0;
          timeout_q   <= 20'd0;
          gap_cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  // Payload path follows the current owner; nothing leaks when no owner
  always_comb begin
    upper_tx_ready   = 1'b0;
    upper_layer_data = 8'h00;
    udp_data_req     = 1'b0;
    icmp_data_req    = 1'b0;
    case (grant_q)
      GNT_UDP: begin
        upper_tx_ready   = udp_tx_ready;
        upper_layer_data = udp_tx_data;
        udp_data_req     = upper_data_req;
      end
      GNT_ICMP: begin
        upper_tx_ready   = icmp_tx_ready;
        upper_layer_data = icmp_tx_data;
        icmp_data_req    = upper_data_req;
      end
      default: begin
      end
    endcase
  end

  assign ip_tx_req           = ip_tx_req_q;
  assign ip_send_type        = ip_type_q;
  assign ip_send_data_length = ip_len_q;
  assign destination_ip_addr = ip_dst_q;
  assign udp_tx_ack          = udp_ack_q;
  assign icmp_tx_ack         = icmp_ack_q;
  assign udp_tx_end          = udp_end_q;
  assign icmp_tx_end         = icmp_end_q;
  assign tx_abort            = abort_q;
  assign dbg_state_o         = state_q;
  assign dbg_grant_o         = grant_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: reset, tie-break, single UDP frame,
// payload routing, stray end, timeout abort and reset mid-frame.
module tb_ip_tx_arbiter;
  import ip_pkg::*;

  typedef logic [95:0] v_t;

  localparam logic [19:0] TO_CYC  = 20'd64;
  localparam logic [7:0]  GAP_CYC = 8'd12;

  logic        clk, rst_n;
  logic        udp_tx_req, udp_tx_ready;
  logic [15:0] udp_send_length;
  logic [31:0] udp_dst_ip;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_ack, udp_data_req, udp_tx_end;
  logic        icmp_tx_req, icmp_tx_ready;
  logic [15:0] icmp_send_length;
  logic [31:0] icmp_dst_ip;
  logic [7:0]  icmp_tx_data;
  logic        icmp_tx_ack, icmp_data_req, icmp_tx_end;
  logic        ip_tx_req;
  logic [7:0]  ip_send_type;
  logic [15:0] ip_send_data_length;
  logic [31:0] destination_ip_addr;
  logic [7:0]  upper_layer_data;
  logic        upper_tx_ready;
  logic        ip_tx_ack, upper_data_req, ip_tx_end, tx_abort;
  state_t      dbg_state;
  grant_t      dbg_grant;

  int n_checks, n_fail;
  int ack_cnt, icmp_ack_cnt, gap_cnt, req_cycles, icmp_grants;
  logic [7:0] exp_q[$];
  logic [7:0] bytes [4];

  ip_tx_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .GAP_CYCLES(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .udp_tx_req(udp_tx_req), .udp_tx_ready(udp_tx_ready),
    .udp_send_length(udp_send_length), .udp_dst_ip(udp_dst_ip),
    .udp_tx_data(udp_tx_data), .udp_tx_ack(udp_tx_ack),
    .udp_data_req(udp_data_req), .udp_tx_end(udp_tx_end),
    .icmp_tx_req(icmp_tx_req), .icmp_tx_ready(icmp_tx_ready),
    .icmp_send_length(icmp_send_length), .icmp_dst_ip(icmp_dst_ip),
    .icmp_tx_data(icmp_tx_data), .icmp_tx_ack(icmp_tx_ack),
    .icmp_data_req(icmp_data_req), .icmp_tx_end(icmp_tx_end),
    .ip_tx_req(ip_tx_req), .ip_send_type(ip_send_type),
    .ip_send_data_length(ip_send_data_length),
    .destination_ip_addr(destination_ip_addr),
    .upper_layer_data(upper_layer_data), .upper_tx_ready(upper_tx_ready),
    .ip_tx_ack(ip_tx_ack), .upper_data_req(upper_data_req),
    .ip_tx_end(ip_tx_end), .tx_abort(tx_abort),
    .dbg_state_o(dbg_state), .dbg_grant_o(dbg_grant)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input v_t got, input v_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input state_t st, input int budget, input string tag);
    int n;
    n = 0;
    while (dbg_state !== st && n < budget) begin
      step();
      n++;
    end
    check(tag, v_t'(dbg_state), v_t'(st));
  endtask

  function automatic logic [72:0] all_outs();
    return {udp_tx_ack, udp_data_req, udp_tx_end,
            icmp_tx_ack, icmp_data_req, icmp_tx_end,
            ip_tx_req, ip_send_type, ip_send_data_length, destination_ip_addr,
            upper_layer_data, upper_tx_ready, tx_abort};
  endfunction

  initial begin
    n_checks = 0; n_fail = 0;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    rst_n = 1'b0;
    udp_tx_req = 0; udp_tx_ready = 0; udp_send_length = 0; udp_dst_ip = 0; udp_tx_data = 0;
    icmp_tx_req = 0; icmp_tx_ready = 0; icmp_send_length = 0; icmp_dst_ip = 0; icmp_tx_data = 0;
    ip_tx_ack = 0; upper_data_req = 0; ip_tx_end = 0;

    // ---- reset state
    repeat (3) step();
    check("reset_outs", v_t'(all_outs()), v_t'(0));
    check("reset_state", v_t'(dbg_state), v_t'(ST_IDLE));
    check("reset_grant", v_t'(dbg_grant), v_t'(GNT_NONE));
    rst_n = 1'b1;
    step();

    // ---- tie after reset: ICMP first, then UDP
    udp_tx_req = 1; udp_send_length = 16'd100; udp_dst_ip = 32'hC0A8_0002;
    icmp_tx_req = 1; icmp_send_length = 16'd64; icmp_dst_ip = 32'h0A00_0001;
    step();
    check("tie_grant", v_t'(dbg_grant), v_t'(GNT_ICMP));
    check("tie_type", v_t'(ip_send_type), v_t'(8'h01));
    check("tie_len", v_t'(ip_send_data_length), v_t'(16'd64));
    check("tie_dst", v_t'(destination_ip_addr), v_t'(32'h0A00_0001));
    ip_tx_ack = 1;
    step();
    check("tie_icmp_ack", v_t'(icmp_tx_ack), v_t'(1));
    check("tie_udp_ack_quiet", v_t'(udp_tx_ack), v_t'(0));
    icmp_tx_req = 0; ip_tx_ack = 0;
    step();
    ip_tx_end = 1;
    step();
    ip_tx_end = 0;
    check("tie_icmp_end", v_t'(icmp_tx_end), v_t'(1));
    check("tie_udp_end_quiet", v_t'(udp_tx_end), v_t'(0));
    icmp_tx_req = 1;
    icmp_grants = 0;
    for (int i = 0; i < 40 && dbg_state !== ST_WAIT_ACK; i++) begin
      step();
      if (dbg_grant === GNT_ICMP) icmp_grants++;
    end
    check("rr_state", v_t'(dbg_state), v_t'(ST_WAIT_ACK));
    check("rr_no_icmp_regrant", v_t'(icmp_grants), v_t'(0));
    check("rr_grant", v_t'(dbg_grant), v_t'(GNT_UDP));
    check("rr_type", v_t'(ip_send_type), v_t'(8'h11));
    udp_tx_req = 0; icmp_tx_req = 0; ip_tx_ack = 1;
    step();
    ip_tx_ack = 0;
    check("rr_udp_ack", v_t'(udp_tx_ack), v_t'(1));
    ip_tx_end = 1;
    step();
    ip_tx_end = 0;
    wait_state(ST_IDLE, 40, "rr_back_idle");

    // ---- single UDP frame
    udp_tx_req = 1; udp_send_length = 16'd100; udp_dst_ip = 32'hC0A8_0002;
    #1;
    check("udp_req_not_early", v_t'(ip_tx_req), v_t'(0));
    step();
    check("udp_req", v_t'(ip_tx_req), v_t'(1));
    check("udp_type", v_t'(ip_send_type), v_t'(8'h11));
    check("udp_len", v_t'(ip_send_data_length), v_t'(16'd100));
    check("udp_dst", v_t'(destination_ip_addr), v_t'(32'hC0A8_0002));
    ack_cnt = 0; icmp_ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      ip_tx_ack = (i < 8);
      step();
      if (udp_tx_ack === 1'b1) ack_cnt++;
      if (icmp_tx_ack === 1'b1) icmp_ack_cnt++;
      if (i == 0) begin
        check("udp_req_drop", v_t'(ip_tx_req), v_t'(0));
        check("udp_xfer", v_t'(dbg_state), v_t'(ST_XFER));
        udp_tx_req = 0;
      end
    end
    check("udp_ack_pulses", v_t'(ack_cnt), v_t'(1));
    check("icmp_ack_pulses", v_t'(icmp_ack_cnt), v_t'(0));

    // payload routing, length change mid-frame
    udp_tx_ready = 1; icmp_tx_ready = 0; icmp_tx_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      udp_tx_data = bytes[i];
      upper_data_req = 1;
      exp_q.push_back(bytes[i]);
      if (i == 2) udp_send_length = 16'd40;
      #1;
      check("data_byte", v_t'(upper_layer_data), v_t'(exp_q.pop_front()));
      check("data_req_udp", v_t'(udp_data_req), v_t'(1));
      check("data_req_icmp", v_t'(icmp_data_req), v_t'(0));
      step();
    end
    upper_data_req = 0;
    check("upper_ready", v_t'(upper_tx_ready), v_t'(1));
    check("len_held", v_t'(ip_send_data_length), v_t'(16'd100));

    // end and gap
    ip_tx_end = 1;
    #1;
    check("udp_end_not_early", v_t'(udp_tx_end), v_t'(0));
    step();
    ip_tx_end = 0;
    check("udp_end", v_t'(udp_tx_end), v_t'(1));
    check("gap_state", v_t'(dbg_state), v_t'(ST_GAP));
    check("gap_ready_zero", v_t'(upper_tx_ready), v_t'(0));
    gap_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) check("udp_end_pulse", v_t'(udp_tx_end), v_t'(0));
      if (dbg_state === ST_GAP) gap_cnt++;
      else break;
    end
    check("gap_len", v_t'(gap_cnt), v_t'(12));
    check("after_gap_idle", v_t'(dbg_state), v_t'(ST_IDLE));
    check("len_after_frame", v_t'(ip_send_data_length), v_t'(16'd100));

    // ---- stray end / data_req while idle
    ip_tx_end = 1; upper_data_req = 1;
    #1;
    check("idle_data_req_gated", v_t'({udp_data_req, icmp_data_req}), v_t'(0));
    step();
    ip_tx_end = 0; upper_data_req = 0;
    check("idle_end_ignored", v_t'({udp_tx_end, icmp_tx_end}), v_t'(0));
    check("idle_stays", v_t'(dbg_state), v_t'(ST_IDLE));

    // ---- timeout in WAIT_ACK
    udp_tx_req = 1;
    step();
    check("to_len_new_grant", v_t'(ip_send_data_length), v_t'(16'd40));
    req_cycles = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ip_tx_req === 1'b1) req_cycles++;
      else break;
    end
    check("to_wait_cycles", v_t'(req_cycles), v_t'(64));
    check("to_abort", v_t'(tx_abort), v_t'(1));
    check("to_state", v_t'(dbg_state), v_t'(ST_IDLE));
    check("to_grant", v_t'(dbg_grant), v_t'(GNT_NONE));
    step();
    check("to_abort_pulse", v_t'(tx_abort), v_t'(0));
    check("to_regrant", v_t'(ip_tx_req), v_t'(1));
    check("to_regrant_state", v_t'(dbg_state), v_t'(ST_WAIT_ACK));
    udp_tx_req = 0; ip_tx_ack = 1;
    step();
    ip_tx_ack = 0; ip_tx_end = 1;
    step();
    ip_tx_end = 0;
    wait_state(ST_IDLE, 40, "to_done_idle");

    // ---- reset during XFER
    icmp_tx_req = 1; icmp_tx_ready = 1; icmp_tx_data = 8'h5A; icmp_send_length = 16'd28;
    step();
    ip_tx_ack = 1;
    step();
    ip_tx_ack = 0;
    step();
    upper_data_req = 1;
    #1;
    check("pre_reset_xfer", v_t'(dbg_state), v_t'(ST_XFER));
    check("pre_reset_data_req", v_t'(icmp_data_req), v_t'(1));
    rst_n = 1'b0;
    #1;
    check("reset_mid_outs", v_t'(all_outs()), v_t'(0));
    check("reset_mid_state", v_t'(dbg_state), v_t'(ST_IDLE));
    upper_data_req = 0;
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_grant", v_t'(dbg_grant), v_t'(GNT_ICMP));
    check("post_reset_req", v_t'(ip_tx_req), v_t'(1));
    check("post_reset_type", v_t'(ip_send_type), v_t'(8'h01));
    check("post_reset_len", v_t'(ip_send_data_length), v_t'(16'd28));
    icmp_tx_req = 0; ip_tx_ack = 1;
    step();
    ip_tx_ack = 0;
    check("post_reset_ack", v_t'(icmp_tx_ack), v_t'(1));
    ip_tx_end = 1;
    step();
    ip_tx_end = 0;
    check("post_reset_end", v_t'(icmp_tx_end), v_t'(1));
    wait_state(ST_IDLE, 40, "post_reset_idle");

    // ---- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
